// File: rtl/native_mem_responder.sv
// rtl/native_mem_responder.sv - picorv32 native-bus memory responder with wait states, strobes, error capture and backdoor
module native_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 0,
    parameter int unsigned COUNT_W     = 16,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_valid,
    input  logic                           mem_instr,
    input  logic [31:0]                    mem_addr,
    input  logic [31:0]                    mem_wdata,
    input  logic [3:0]                     mem_wstrb,
    output logic                           mem_ready,
    output logic [31:0]                    mem_rdata,
    output logic [COUNT_W-1:0]             fetch_count,
    output logic [COUNT_W-1:0]             load_count,
    output logic [COUNT_W-1:0]             store_count,
    output logic                           err_sticky,
    output logic [31:0]                    err_addr,
    output logic                           proto_err,
    input  logic                           dbg_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
    input  logic [31:0]                    dbg_wdata,
    output logic [31:0]                    dbg_rdata
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic capture, complete, abort;

    logic [31:0] mem [DEPTH_WORDS];

    // Request captured in IDLE; used while waiting out the latency
    logic          req_instr;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          req_ok;
    logic [AW-1:0] req_idx;

    // Live address decode (offset from base, range and alignment)
    logic [32:0] off;
    logic [31:0] word_off;
    logic        addr_ok;

    assign off      = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
    assign word_off = {2'b00, off[31:2]};
    assign addr_ok  = !off[32] && (word_off < 32'(DEPTH_WORDS)) && (off[1:0] == 2'b00);

    // With zero latency the access completes on the capture edge, so use live inputs then
    logic          acc_instr;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic          acc_ok;
    logic [AW-1:0] acc_idx;
    logic          in_idle;

    assign in_idle   = (state == S_IDLE);
    assign acc_instr = in_idle ? mem_instr         : req_instr;
    assign acc_addr  = in_idle ? mem_addr          : req_addr;
    assign acc_wdata = in_idle ? mem_wdata         : req_wdata;
    assign acc_wstrb = in_idle ? mem_wstrb         : req_wstrb;
    assign acc_ok    = in_idle ? addr_ok           : req_ok;
    assign acc_idx   = in_idle ? word_off[AW-1:0]  : req_idx;

    logic dbg_ok;
    assign dbg_ok    = (32'(dbg_addr) < 32'(DEPTH_WORDS));

    assign mem_ready = (state == S_RESP);

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        complete  = 1'b1;
                        state_nxt = S_RESP;
                    end else begin
                        wait_cnt_nxt = 4'(LATENCY);
                        state_nxt    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!mem_valid) begin
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt <= 4'd1) begin
                    complete  = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request capture, read data, counters, sticky errors and backdoor readout
    always_ff @(posedge clk) begin
        if (reset) begin
            req_instr   <= 1'b0;
            req_addr    <= 32'd0;
            req_wdata   <= 32'd0;
            req_wstrb   <= 4'd0;
            req_ok      <= 1'b0;
            req_idx     <= '0;
            mem_rdata   <= 32'd0;
            fetch_count <= '0;
            load_count  <= '0;
            store_count <= '0;
            err_sticky  <= 1'b0;
            err_addr    <= 32'd0;
            proto_err   <= 1'b0;
            dbg_rdata   <= 32'd0;
        end else begin
            dbg_rdata <= dbg_ok ? mem[dbg_addr] : ERR_DATA;
            if (capture) begin
                req_instr <= mem_instr;
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
                req_wstrb <= mem_wstrb;
                req_ok    <= addr_ok;
                req_idx   <= word_off[AW-1:0];
            end
            if (abort) begin
                proto_err <= 1'b1;
            end
            if (complete) begin
                if (acc_wstrb == 4'd0) begin
                    mem_rdata <= acc_ok ? mem[acc_idx] : ERR_DATA;
                    if (acc_instr) begin
                        if (fetch_count != {COUNT_W{1'b1}}) fetch_count <= fetch_count + COUNT_W'(1);
                    end else begin
                        if (load_count != {COUNT_W{1'b1}}) load_count <= load_count + COUNT_W'(1);
                    end
                end else if (!acc_instr) begin
                    if (store_count != {COUNT_W{1'b1}}) store_count <= store_count + COUNT_W'(1);
                end
                if (!acc_ok) begin
                    err_sticky <= 1'b1;
                    if (!err_sticky) err_addr <= acc_addr;
                end
            end
        end
    end

    // Memory array: backdoor full-word write first, bus strobed bytes override on collision
    always_ff @(posedge clk) begin
        if (dbg_we && dbg_ok) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (complete && !reset && acc_ok && (acc_wstrb != 4'd0)) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_native_mem_responder.sv
// tb/tb_native_mem_responder.sv - directed bench for native_mem_responder with a bus-level model
module tb_native_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        valid [3];
    logic        instr [3];
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        dbg_we [3];
    logic [9:0]  dbg_addr [3];
    logic [31:0] dbg_wdata [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        err [3];
    logic [31:0] eaddr [3];
    logic        perr [3];
    logic [31:0] dbg_rdata [3];
    logic [3:0]  fc0, lc0, sc0;
    logic [15:0] fc1, lc1, sc1, fc2, lc2, sc2;
    logic [15:0] fc [3];
    logic [15:0] lc [3];
    logic [15:0] sc [3];

    native_mem_responder #(.LATENCY(0), .COUNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
        .fetch_count(fc0), .load_count(lc0), .store_count(sc0), .err_sticky(err[0]), .err_addr(eaddr[0]),
        .proto_err(perr[0]), .dbg_we(dbg_we[0]), .dbg_addr(dbg_addr[0]), .dbg_wdata(dbg_wdata[0]),
        .dbg_rdata(dbg_rdata[0]));

    native_mem_responder #(.LATENCY(3), .COUNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
        .fetch_count(fc1), .load_count(lc1), .store_count(sc1), .err_sticky(err[1]), .err_addr(eaddr[1]),
        .proto_err(perr[1]), .dbg_we(dbg_we[1]), .dbg_addr(dbg_addr[1]), .dbg_wdata(dbg_wdata[1]),
        .dbg_rdata(dbg_rdata[1]));

    native_mem_responder #(.LATENCY(5), .COUNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .mem_valid(valid[2]), .mem_instr(instr[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]),
        .fetch_count(fc2), .load_count(lc2), .store_count(sc2), .err_sticky(err[2]), .err_addr(eaddr[2]),
        .proto_err(perr[2]), .dbg_we(dbg_we[2]), .dbg_addr(dbg_addr[2]), .dbg_wdata(dbg_wdata[2]),
        .dbg_rdata(dbg_rdata[2]));

    always_comb begin
        fc[0] = {12'd0, fc0}; lc[0] = {12'd0, lc0}; sc[0] = {12'd0, sc0};
        fc[1] = fc1;          lc[1] = lc1;          sc[1] = sc1;
        fc[2] = fc2;          lc[2] = lc2;          sc[2] = sc2;
    end

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Bus-level model: word array, counters, sticky error state, last read data
    logic [31:0] mmem [3][1024];
    int          exp_f [3];
    int          exp_l [3];
    int          exp_s [3];
    logic        exp_err [3];
    logic [31:0] exp_eaddr [3];
    logic        exp_perr [3];
    logic [31:0] last_rd [3];
    int          lat [3]  = '{0, 3, 5};
    int          cmax [3] = '{15, 65535, 65535};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v < m) ? v + 1 : v;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            exp_f[d] = 0; exp_l[d] = 0; exp_s[d] = 0;
            exp_err[d] = 1'b0; exp_eaddr[d] = 32'd0; exp_perr[d] = 1'b0; last_rd[d] = 32'd0;
        end
    endtask

    // Every cycle, the visible status outputs of all three responders must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d fetch_count", d), {16'd0, fc[d]}, exp_f[d]);
                chk($sformatf("d%0d load_count", d), {16'd0, lc[d]}, exp_l[d]);
                chk($sformatf("d%0d store_count", d), {16'd0, sc[d]}, exp_s[d]);
                chk($sformatf("d%0d err_sticky", d), {31'd0, err[d]}, {31'd0, exp_err[d]});
                chk($sformatf("d%0d err_addr", d), eaddr[d], exp_eaddr[d]);
                chk($sformatf("d%0d proto_err", d), {31'd0, perr[d]}, {31'd0, exp_perr[d]});
                chk($sformatf("d%0d mem_rdata", d), rdata[d], last_rd[d]);
            end
        end
    end

    task automatic dbg_wr(input int d, input int idx, input logic [31:0] v);
        @(posedge clk); #1;
        dbg_we[d] = 1'b1; dbg_addr[d] = 10'(idx); dbg_wdata[d] = v;
        @(posedge clk); #1;
        dbg_we[d] = 1'b0;
        mmem[d][idx] = v;
    endtask

    task automatic dbg_rd(input int d, input int idx, output logic [31:0] v);
        @(posedge clk); #1;
        dbg_addr[d] = 10'(idx);
        @(posedge clk); #1;
        chk($sformatf("d%0d dbg_rdata[%0d]", d, idx), dbg_rdata[d], mmem[d][idx]);
        v = dbg_rdata[d];
    endtask

    task automatic bus(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, output logic [31:0] rd);
        logic ok;
        int idx;
        int n;
        bit got;
        ok  = (a < 32'd4096) && (a[1:0] == 2'b00);
        idx = int'(a >> 2);
        @(posedge clk); #1;
        valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws; instr[d] = ins;
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            got = ready[d];
        end
        valid[d] = 1'b0; wstrb[d] = 4'd0; instr[d] = 1'b0;
        chk($sformatf("d%0d ready seen @%h", d, a), {31'd0, got}, 32'd1);
        chk($sformatf("d%0d latency @%h", d, a), n, lat[d] + 1);
        if (ws != 4'd0) begin
            if (ok) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) mmem[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
            if (!ins) exp_s[d] = sat(exp_s[d], cmax[d]);
        end else begin
            last_rd[d] = ok ? mmem[d][idx] : 32'hDEAD_BEEF;
            if (ins) exp_f[d] = sat(exp_f[d], cmax[d]);
            else     exp_l[d] = sat(exp_l[d], cmax[d]);
        end
        if (!ok) begin
            if (!exp_err[d]) exp_eaddr[d] = a;
            exp_err[d] = 1'b1;
        end
        chk($sformatf("d%0d rdata @%h", d, a), rdata[d], last_rd[d]);
        rd = rdata[d];
        @(posedge clk); #1;
        chk($sformatf("d%0d ready one cycle", d), {31'd0, ready[d]}, 32'd0);
    endtask

    task automatic run_program(input int d, output logic [31:0] ld);
        logic [31:0] r;
        bus(d, 32'd0,  32'd0, 4'd0, 1'b1, r);
        chk($sformatf("d%0d first fetch", d), r, 32'h0FF0_0093);
        bus(d, 32'd4,  32'd0, 4'd0, 1'b1, r);
        bus(d, 32'd8,  32'd0, 4'd0, 1'b1, r);
        bus(d, 32'd256, 32'd255, 4'hF, 1'b0, r);
        bus(d, 32'd12, 32'd0, 4'd0, 1'b1, r);
        bus(d, 32'd256, 32'd0, 4'd0, 1'b0, ld);
        for (int i = 0; i < 3; i++) bus(d, 32'd16, 32'd0, 4'd0, 1'b1, r);
        chk($sformatf("d%0d jal fetch", d), r, 32'h0000_006F);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 1'b0; instr[d] = 1'b0; addr[d] = 32'd0; wdata[d] = 32'd0; wstrb[d] = 4'd0;
            dbg_we[d] = 1'b0; dbg_addr[d] = 10'd0; dbg_wdata[d] = 32'd0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset mem_ready", {31'd0, ready[0]}, 32'd0);
        chk("reset dbg_rdata", dbg_rdata[0], 32'd0);

        // Program image seen by the core, replayed as its bus trace
        for (int d = 0; d < 2; d++) begin
            dbg_wr(d, 0, 32'h0FF0_0093);
            dbg_wr(d, 1, 32'h1000_0113);
            dbg_wr(d, 2, 32'h0011_2023);
            dbg_wr(d, 3, 32'h0001_2183);
            dbg_wr(d, 4, 32'h0000_006F);
        end
        for (int d = 0; d < 2; d++) begin
            run_program(d, r);
            chk($sformatf("d%0d x3 load value", d), r, 32'h0000_00FF);
            dbg_rd(d, 64, r);
            chk($sformatf("d%0d dbg word 64", d), r, 32'h0000_00FF);
            chk($sformatf("d%0d store_count lit", d), {16'd0, sc[d]}, 32'd1);
            chk($sformatf("d%0d load_count lit", d), {16'd0, lc[d]}, 32'd1);
            chk($sformatf("d%0d fetch_count lit", d), {16'd0, fc[d]}, 32'd7);
        end

        // Byte strobes
        dbg_wr(1, 64, 32'h1122_3344);
        bus(1, 32'd256, 32'hAABB_CCDD, 4'b0101, 1'b0, r);
        dbg_rd(1, 64, r);
        chk("strobe merge", r, 32'h11BB_33DD);

        // Error accesses
        bus(1, 32'd4096, 32'd0, 4'd0, 1'b0, r);
        chk("oob read data", r, 32'hDEAD_BEEF);
        chk("oob err_sticky", {31'd0, err[1]}, 32'd1);
        chk("oob err_addr", eaddr[1], 32'd4096);
        bus(1, 32'h102, 32'd0, 4'd0, 1'b0, r);
        chk("misaligned read data", r, 32'hDEAD_BEEF);
        chk("err_addr kept", eaddr[1], 32'd4096);
        bus(1, 32'h101, 32'h1234_5678, 4'hF, 1'b0, r);
        dbg_rd(1, 64, r);
        chk("misaligned write dropped", r, 32'h11BB_33DD);

        // Bus write and backdoor write collide on the same word and edge
        @(posedge clk); #1;
        valid[0] = 1'b1; addr[0] = 32'h200; wdata[0] = 32'hAABB_CCDD; wstrb[0] = 4'b0011; instr[0] = 1'b0;
        dbg_we[0] = 1'b1; dbg_addr[0] = 10'd128; dbg_wdata[0] = 32'h1122_3344;
        @(posedge clk); #1;
        chk("collision ready", {31'd0, ready[0]}, 32'd1);
        valid[0] = 1'b0; wstrb[0] = 4'd0; dbg_we[0] = 1'b0;
        mmem[0][128] = 32'h1122_CCDD;
        exp_s[0] = sat(exp_s[0], cmax[0]);
        dbg_rd(0, 128, r);
        chk("collision merge", r, 32'h1122_CCDD);

        // Saturation with 4-bit counters
        for (int i = 0; i < 20; i++) bus(0, 32'd0, 32'd0, 4'd0, 1'b0, r);
        chk("load_count saturated", {16'd0, lc[0]}, 32'd15);

        // Protocol error: valid dropped after two cycles in WAIT
        dbg_wr(2, 192, 32'h5555_AAAA);
        @(posedge clk); #1;
        valid[2] = 1'b1; addr[2] = 32'h300; wdata[2] = 32'hCAFE_F00D; wstrb[2] = 4'hF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort no ready early", {31'd0, ready[2]}, 32'd0);
        end
        valid[2] = 1'b0; wstrb[2] = 4'd0;
        @(posedge clk); #1;
        exp_perr[2] = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort no ready", {31'd0, ready[2]}, 32'd0);
        end
        chk("proto_err lit", {31'd0, perr[2]}, 32'd1);
        dbg_rd(2, 192, r);
        chk("aborted write dropped", r, 32'h5555_AAAA);

        // Reset during WAIT
        dbg_wr(2, 10, 32'h600D_F00D);
        bus(2, 32'd40, 32'd0, 4'd0, 1'b0, r);
        @(posedge clk); #1;
        valid[2] = 1'b1; addr[2] = 32'd40; wstrb[2] = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        valid[2] = 1'b0;
        clear_model();
        chk("reset ready", {31'd0, ready[2]}, 32'd0);
        chk("reset dbg_rdata d2", dbg_rdata[2], 32'd0);
        chk("reset rdata d2", rdata[2], 32'd0);
        chk("reset load_count d2", {16'd0, lc[2]}, 32'd0);
        chk("reset proto_err d2", {31'd0, perr[2]}, 32'd0);
        reset = 1'b0;
        dbg_rd(2, 10, r);
        chk("memory retained", r, 32'h600D_F00D);
        bus(2, 32'd40, 32'd0, 4'd0, 1'b0, r);
        chk("post-reset read", r, 32'h600D_F00D);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
